// File: rtl/ras_spec_pkg.sv
// Shared constants and types for the speculative return address stack.
package ras_spec_pkg;

  // Return offsets: compressed call is 2 bytes, normal call is 4 bytes.
  localparam int RAS_RVC_OFS = 2;
  localparam int RAS_STD_OFS = 4;

  // Decoded stack operation for one cycle (restore handled separately).
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_PUSHPOP = 2'd3
  } ras_op_e;

endpackage

// File: rtl/ras_spec_if.sv
// Front-end request/response bundle for the return address stack.
interface ras_spec_if #(
  parameter int WIDTH    = 64,
  parameter int CKPT_NUM = 4
);
  localparam int ID_W = $clog2(CKPT_NUM);

  logic             push_i;
  logic             pop_i;
  logic [WIDTH-1:0] pc_i;
  logic             rvc_i;
  logic             ckpt_save_i;
  logic [ID_W-1:0]  ckpt_save_id_i;
  logic             restore_i;
  logic [ID_W-1:0]  restore_id_i;
  logic [WIDTH-1:0] top_addr_o;
  logic             top_valid_o;
  logic             empty_o;
  logic             full_o;

  // Front end drives requests, observes the prediction.
  modport master (
    output push_i, pop_i, pc_i, rvc_i, ckpt_save_i, ckpt_save_id_i,
           restore_i, restore_id_i,
    input  top_addr_o, top_valid_o, empty_o, full_o
  );

  // Stack consumes requests, produces the prediction.
  modport slave (
    input  push_i, pop_i, pc_i, rvc_i, ckpt_save_i, ckpt_save_id_i,
           restore_i, restore_id_i,
    output top_addr_o, top_valid_o, empty_o, full_o
  );
endinterface

// File: rtl/ras_spec_ckpt_table.sv
// Checkpoint register file: one write port, one combinational read port.
// Slot payload is packed {sp, cnt, top}. A per-slot saved flag exists only
// so the top level can flag restores from slots never written since reset.
module ras_spec_ckpt_table #(
  parameter int CKPT_NUM = 4,
  parameter int SLOT_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        i_we,
  input  logic [$clog2(CKPT_NUM)-1:0] i_wid,
  input  logic [SLOT_W-1:0]           i_wdata,
  input  logic [$clog2(CKPT_NUM)-1:0] i_rid,
  output logic [SLOT_W-1:0]           o_rdata,
  output logic                        o_valid
);
  logic [SLOT_W-1:0]   r_mem [CKPT_NUM];
  logic [CKPT_NUM-1:0] r_saved;

  // Slot storage, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_wid] <= i_wdata;
  end

  // Track which slots hold a checkpoint taken since the last reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)     r_saved        <= '0;
    else if (i_we) r_saved[i_wid] <= 1'b1;
  end

  assign o_rdata = r_mem[i_rid];
  assign o_valid = r_saved[i_rid];
endmodule

// File: rtl/ras_spec.sv
// Speculative return address stack with combined push+pop and
// checkpoint/restore for misprediction repair.
module ras_spec
  import ras_spec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 8,
  parameter int CKPT_NUM = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  ras_spec_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ID_W   = $clog2(CKPT_NUM);
  localparam int SLOT_W = PTR_W + CNT_W + WIDTH;

  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_entry [DEPTH];

  ras_op_e           w_op;
  logic              w_empty, w_full;
  logic [WIDTH-1:0]  w_push_data;
  logic [PTR_W-1:0]  w_sp_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_push_we;
  logic [PTR_W-1:0]  w_push_idx;
  logic [WIDTH-1:0]  w_top_nx;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [WIDTH-1:0]  w_wr_data;
  logic [SLOT_W-1:0] w_rd_slot;
  logic              w_rd_valid;
  logic [PTR_W-1:0]  w_rd_sp;
  logic [CNT_W-1:0]  w_rd_cnt;
  logic [WIDTH-1:0]  w_rd_top;
  logic              w_save_we;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_push_data = bus.pc_i + (bus.rvc_i ? WIDTH'(RAS_RVC_OFS) : WIDTH'(RAS_STD_OFS));

  // Op decode: push+pop on an empty stack degrades to a plain push,
  // pop on an empty stack is ignored.
  always_comb begin
    w_op = OP_NONE;
    case ({bus.push_i, bus.pop_i})
      2'b10: w_op = OP_PUSH;
      2'b01: w_op = w_empty ? OP_NONE : OP_POP;
      2'b11: w_op = w_empty ? OP_PUSH : OP_PUSHPOP;
      default: w_op = OP_NONE;
    endcase
  end

  // Next sp/cnt and the push write target. Overflow wraps sp and clobbers
  // the oldest entry while cnt saturates at DEPTH.
  always_comb begin
    w_sp_nx    = r_sp;
    w_cnt_nx   = r_cnt;
    w_push_we  = 1'b0;
    w_push_idx = r_sp;
    case (w_op)
      OP_PUSH: begin
        w_sp_nx    = r_sp + PTR_W'(1);
        w_cnt_nx   = w_full ? r_cnt : r_cnt + CNT_W'(1);
        w_push_we  = 1'b1;
        w_push_idx = r_sp + PTR_W'(1);
      end
      OP_POP: begin
        w_sp_nx  = r_sp - PTR_W'(1);
        w_cnt_nx = r_cnt - CNT_W'(1);
      end
      OP_PUSHPOP: begin
        w_push_we  = 1'b1;
        w_push_idx = r_sp;
      end
      default: ;
    endcase
  end

  // Top entry as it will look after this cycle, for checkpointing.
  assign w_top_nx = w_push_we ? w_push_data : r_entry[w_sp_nx];

  // Restore owns the cycle: it drops push/pop and any save, including a
  // save to the slot being restored (which thus reads the old contents).
  assign w_save_we = bus.ckpt_save_i && !bus.restore_i;

  ras_spec_ckpt_table #(
    .CKPT_NUM (CKPT_NUM),
    .SLOT_W   (SLOT_W)
  ) u_ckpt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_save_we),
    .i_wid   (bus.ckpt_save_id_i),
    .i_wdata ({w_sp_nx, w_cnt_nx, w_top_nx}),
    .i_rid   (bus.restore_id_i),
    .o_rdata (w_rd_slot),
    .o_valid (w_rd_valid)
  );

  assign w_rd_sp  = w_rd_slot[SLOT_W-1 -: PTR_W];
  assign w_rd_cnt = w_rd_slot[WIDTH +: CNT_W];
  assign w_rd_top = w_rd_slot[WIDTH-1:0];

  // Single entry write port: restore repairs the top entry, else push data.
  always_comb begin
    w_wr_en   = w_push_we;
    w_wr_idx  = w_push_idx;
    w_wr_data = w_push_data;
    if (bus.restore_i) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = w_rd_sp;
      w_wr_data = w_rd_top;
    end
  end

  // Stack pointer and occupancy; reset beats every request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (bus.restore_i) begin
      r_sp  <= w_rd_sp;
      r_cnt <= w_rd_cnt;
    end else begin
      r_sp  <= w_sp_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  // Entry array, not reset; writes are suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_en) r_entry[w_wr_idx] <= w_wr_data;
  end

  // Restoring a slot that was never saved since reset yields garbage.
  a_restore_saved: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.restore_i |-> w_rd_valid);

  assign bus.top_addr_o  = r_entry[r_sp];
  assign bus.top_valid_o = !w_empty;
  assign bus.empty_o     = w_empty;
  assign bus.full_o      = w_full;
endmodule
